// File: rtl/pe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the PE-array sequencing controller: default address
// and reduction-length widths, the controller state encoding and a small
// state-decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pe_ctrl_pkg;

   localparam int ADDR_WIDTH_DEF = 12;
   localparam int K_WIDTH_DEF    = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FETCH = 3'd2,
      ST_DRAIN = 3'd3,
      ST_OUT   = 3'd4
   } pe_state_e;

   // Controller is busy in every state except IDLE.
   function automatic logic state_busy(input pe_state_e s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pe_seq_ctrl_if
// Bundles the job-descriptor handshake, the SRAM read port, the PE-array
// control strobes and the result handshake of pe_seq_ctrl.
//   master : job issuer / environment (drives cfg_*, abort, out_ready)
//   slave  : the controller (drives cfg_ready, mem_rd_en, a_addr, w_addr,
//            pe_clear, pe_enable, out_valid, busy)
// -----------------------------------------------------------------------------
interface pe_seq_ctrl_if
   import pe_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int K_WIDTH    = K_WIDTH_DEF
);

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [K_WIDTH-1:0]    cfg_k_len;
   logic [ADDR_WIDTH-1:0] cfg_a_base;
   logic [ADDR_WIDTH-1:0] cfg_w_base;
   logic                  abort;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  pe_clear;
   logic                  pe_enable;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;

   modport master (
      output cfg_valid, cfg_k_len, cfg_a_base, cfg_w_base, abort, out_ready,
      input  cfg_ready, mem_rd_en, a_addr, w_addr, pe_clear, pe_enable,
             out_valid, busy
   );

   modport slave (
      input  cfg_valid, cfg_k_len, cfg_a_base, cfg_w_base, abort, out_ready,
      output cfg_ready, mem_rd_en, a_addr, w_addr, pe_clear, pe_enable,
             out_valid, busy
   );

endinterface

// File: rtl/pe_seq_ctrl_addr_gen.sv
// -----------------------------------------------------------------------------
// pe_addr_gen
// Activation/weight address and step-index generator.
//   clk, rstn            : clock, asynchronous active-low reset
//   load_i               : load base addresses, clear the step index
//   step_i               : advance both addresses and the index by one
//   a_base_i, w_base_i   : base addresses captured on load_i
//   k_len_i              : latched reduction length (used for last_o)
//   last_o               : current index is k_len_i-1
//   a_addr_o, w_addr_o   : registered SRAM read addresses (wrap modulo 2^AW)
// -----------------------------------------------------------------------------
module pe_addr_gen
   import pe_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int K_WIDTH    = K_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [ADDR_WIDTH-1:0] a_base_i,
   input  logic [ADDR_WIDTH-1:0] w_base_i,
   input  logic [K_WIDTH-1:0]    k_len_i,
   output logic                  last_o,
   output logic [ADDR_WIDTH-1:0] a_addr_o,
   output logic [ADDR_WIDTH-1:0] w_addr_o
);

   localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [K_WIDTH-1:0]    K_ONE = {{(K_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
   logic [K_WIDTH-1:0]    idx_q, idx_d;

   // Next-value selection: load has priority over step; addresses wrap naturally.
   always_comb begin
      a_addr_d = a_addr_q;
      w_addr_d = w_addr_q;
      idx_d    = idx_q;
      if (load_i) begin
         a_addr_d = a_base_i;
         w_addr_d = w_base_i;
         idx_d    = {K_WIDTH{1'b0}};
      end else if (step_i) begin
         a_addr_d = a_addr_q + A_ONE;
         w_addr_d = w_addr_q + A_ONE;
         idx_d    = idx_q + K_ONE;
      end else begin
         a_addr_d = a_addr_q;
         w_addr_d = w_addr_q;
         idx_d    = idx_q;
      end
   end

   // Address and index registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_addr_q <= {ADDR_WIDTH{1'b0}};
         w_addr_q <= {ADDR_WIDTH{1'b0}};
         idx_q    <= {K_WIDTH{1'b0}};
      end else begin
         a_addr_q <= a_addr_d;
         w_addr_q <= w_addr_d;
         idx_q    <= idx_d;
      end
   end

   // Index never exceeds k_len-1, so a K_WIDTH counter covers k_len = 2^K-1.
   assign last_o   = (idx_q == (k_len_i - K_ONE));
   assign a_addr_o = a_addr_q;
   assign w_addr_o = w_addr_q;

endmodule

// File: rtl/pe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pe_seq_ctrl
// Sequences one dot-product job on a PE array: accepts a job descriptor,
// clears the accumulators, streams k_len SRAM reads, lets the last read
// drain into the array and then presents the result until it is taken.
//   clk  : single clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : pe_seq_ctrl_if.slave (job handshake, abort, SRAM read port,
//          PE clear/enable, result handshake, busy)
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module pe_seq_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int K_WIDTH    = K_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   pe_seq_ctrl_if.slave bus
);

   pe_state_e             state_q, state_d;
   logic [K_WIDTH-1:0]    k_len_q, k_len_d;
   logic                  cfg_ready_q, cfg_ready_d;
   logic                  busy_q, busy_d;
   logic                  pe_clear_q, pe_clear_d;
   logic                  mem_rd_en_q, mem_rd_en_d;
   logic                  pe_enable_q, pe_enable_d;
   logic                  out_valid_q, out_valid_d;

   logic                  accept_s;
   logic                  abort_s;
   logic                  load_s;
   logic                  step_s;
   logic                  last_s;
   logic [ADDR_WIDTH-1:0] a_addr_s;
   logic [ADDR_WIDTH-1:0] w_addr_s;

   // cfg_ready_q is only high in IDLE, and stays low until the first edge
   // after reset release.
   assign accept_s = bus.cfg_valid & cfg_ready_q;
   assign abort_s  = bus.abort & (state_q != ST_IDLE);

   // Next-state logic; abort overrides every transition outside IDLE.
   always_comb begin
      state_d = state_q;
      k_len_d = k_len_q;
      load_s  = 1'b0;
      step_s  = 1'b0;
      if (abort_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  state_d = ST_CLEAR;
                  k_len_d = bus.cfg_k_len;
                  load_s  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CLEAR: begin
               if (k_len_q != {K_WIDTH{1'b0}}) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_OUT;
               end
            end
            ST_FETCH: begin
               step_s = 1'b1;
               if (last_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_DRAIN: begin
               state_d = ST_OUT;
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_OUT;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state so every output is a flop that lines
   // up with the state it belongs to.
   always_comb begin
      cfg_ready_d = (state_d == ST_IDLE);
      busy_d      = state_busy(state_d);
      pe_clear_d  = (state_d == ST_CLEAR);
      mem_rd_en_d = (state_d == ST_FETCH);
      out_valid_d = (state_d == ST_OUT);
      // Enable follows the read strobe by one cycle (read latency); an abort
      // discards the read that is still in flight.
      pe_enable_d = mem_rd_en_q & ~abort_s;
   end

   // State, latched job length and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         k_len_q     <= {K_WIDTH{1'b0}};
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         pe_clear_q  <= 1'b0;
         mem_rd_en_q <= 1'b0;
         pe_enable_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         pe_clear_q  <= pe_clear_d;
         mem_rd_en_q <= mem_rd_en_d;
         pe_enable_q <= pe_enable_d;
         out_valid_q <= out_valid_d;
      end
   end

   pe_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .K_WIDTH    (K_WIDTH)
   ) u_addr_gen (
      .clk      (clk),
      .rstn     (rstn),
      .load_i   (load_s),
      .step_i   (step_s),
      .a_base_i (bus.cfg_a_base),
      .w_base_i (bus.cfg_w_base),
      .k_len_i  (k_len_q),
      .last_o   (last_s),
      .a_addr_o (a_addr_s),
      .w_addr_o (w_addr_s)
   );

   assign bus.cfg_ready = cfg_ready_q;
   assign bus.busy      = busy_q;
   assign bus.pe_clear  = pe_clear_q;
   assign bus.mem_rd_en = mem_rd_en_q;
   assign bus.pe_enable = pe_enable_q;
   assign bus.out_valid = out_valid_q;
   assign bus.a_addr    = a_addr_s;
   assign bus.w_addr    = w_addr_s;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_seq_ctrl
// Directed bench for pe_seq_ctrl: SRAM + PE accumulator model, expected
// results queued when a job is issued and compared when the result is taken.
// -----------------------------------------------------------------------------
module tb_pe_seq_ctrl;
   import pe_ctrl_pkg::*;

   localparam int AW = 12;
   localparam int KW = 10;

   logic clk = 1'b0;
   logic rstn;
   int   errors = 0;
   int   checks = 0;

   pe_seq_ctrl_if #(.ADDR_WIDTH(AW), .K_WIDTH(KW)) bus ();

   pe_seq_ctrl #(.ADDR_WIDTH(AW), .K_WIDTH(KW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  amem [0:4095];
   logic [7:0]  wmem [0:4095];
   logic [7:0]  a_rd, w_rd;
   logic [31:0] acc;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_acc(input int k, input logic [11:0] ab, input logic [11:0] wb);
      logic [31:0] s;
      logic [11:0] aa, ww;
      s = 32'd0;
      for (int i = 0; i < k; i++) begin
         aa = ab + 12'(i);
         ww = wb + 12'(i);
         s  = s + 32'(amem[aa]) * 32'(wmem[ww]);
      end
      return s;
   endfunction

   // SRAM with one-cycle read latency feeding a single PE accumulator.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc  <= 32'd0;
         a_rd <= 8'd0;
         w_rd <= 8'd0;
      end else begin
         if (bus.pe_clear === 1'b1) acc <= 32'd0;
         else if (bus.pe_enable === 1'b1) acc <= acc + 32'(a_rd) * 32'(w_rd);
         if (bus.mem_rd_en === 1'b1) begin
            a_rd <= amem[bus.a_addr];
            w_rd <= wmem[bus.w_addr];
         end
      end
   end

   // Scoreboard: pop the expected result on each result handshake.
   always @(posedge clk) begin
      if (rstn === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) check("sb_unexpected_result", 32'(exp_q.size()), 32'd1);
         else check("acc", acc, exp_q.pop_front());
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd0);
      check({tag, "_busy"},      32'(bus.busy),      32'd0);
      check({tag, "_mem_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
      check({tag, "_pe_clear"},  32'(bus.pe_clear),  32'd0);
      check({tag, "_pe_enable"}, 32'(bus.pe_enable), 32'd0);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_a_addr"},    32'(bus.a_addr),    32'd0);
      check({tag, "_w_addr"},    32'(bus.w_addr),    32'd0);
   endtask

   // One complete job, checked cycle by cycle. hold = cycles out_ready stays
   // low in OUT; chain = present the next descriptor while in OUT; abort_hs =
   // raise abort together with the result handshake.
   task automatic run_job(input string tag, input int k, input logic [11:0] ab,
                          input logic [11:0] wb, input logic [31:0] exp_acc,
                          input int hold, input bit chain, input int nk,
                          input logic [11:0] nab, input logic [11:0] nwb,
                          input bit abort_hs);
      logic [11:0] ea, ew;
      check({tag, "_ready_pre"}, 32'(bus.cfg_ready), 32'd1);
      bus.cfg_valid  = 1'b1;
      bus.cfg_k_len  = 10'(k);
      bus.cfg_a_base = ab;
      bus.cfg_w_base = wb;
      exp_q.push_back(exp_acc);
      tick();
      bus.cfg_valid = 1'b0;
      check({tag, "_clr"},        32'(bus.pe_clear),  32'd1);
      check({tag, "_clr_busy"},   32'(bus.busy),      32'd1);
      check({tag, "_clr_ready"},  32'(bus.cfg_ready), 32'd0);
      check({tag, "_clr_en"},     32'(bus.pe_enable), 32'd0);
      check({tag, "_clr_rd"},     32'(bus.mem_rd_en), 32'd0);
      for (int i = 0; i < k; i++) begin
         tick();
         ea = ab + 12'(i);
         ew = wb + 12'(i);
         check($sformatf("%s_rd%0d", tag, i),  32'(bus.mem_rd_en), 32'd1);
         check($sformatf("%s_a%0d", tag, i),   32'(bus.a_addr),    32'(ea));
         check($sformatf("%s_w%0d", tag, i),   32'(bus.w_addr),    32'(ew));
         check($sformatf("%s_clr%0d", tag, i), 32'(bus.pe_clear),  32'd0);
         check($sformatf("%s_en%0d", tag, i),  32'(bus.pe_enable), (i > 0) ? 32'd1 : 32'd0);
      end
      if (k > 0) begin
         tick();
         check({tag, "_drain_rd"}, 32'(bus.mem_rd_en), 32'd0);
         check({tag, "_drain_en"}, 32'(bus.pe_enable), 32'd1);
         check({tag, "_drain_ov"}, 32'(bus.out_valid), 32'd0);
      end
      tick();
      check({tag, "_latency_ov"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_out_en"},     32'(bus.pe_enable), 32'd0);
      check({tag, "_out_rd"},     32'(bus.mem_rd_en), 32'd0);
      check({tag, "_out_busy"},   32'(bus.busy),      32'd1);
      if (chain) begin
         bus.cfg_valid  = 1'b1;
         bus.cfg_k_len  = 10'(nk);
         bus.cfg_a_base = nab;
         bus.cfg_w_base = nwb;
      end
      for (int h = 0; h < hold; h++) begin
         tick();
         check($sformatf("%s_hold_ov%0d", tag, h),  32'(bus.out_valid), 32'd1);
         check($sformatf("%s_hold_rdy%0d", tag, h), 32'(bus.cfg_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      bus.abort     = abort_hs;
      tick();
      bus.out_ready = 1'b0;
      bus.abort     = 1'b0;
      check({tag, "_post_ov"},    32'(bus.out_valid), 32'd0);
      check({tag, "_post_busy"},  32'(bus.busy),      32'd0);
      check({tag, "_post_ready"}, 32'(bus.cfg_ready), 32'd1);
      check({tag, "_post_clr"},   32'(bus.pe_clear),  32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         amem[i] = 8'((i * 3 + 1) % 17);
         wmem[i] = 8'((i % 5) + 1);
      end
      for (int i = 0; i < 4; i++) begin
         amem['h010 + i] = 8'(i + 1);
         wmem['h200 + i] = 8'd2;
      end
      rstn           = 1'b0;
      bus.cfg_valid  = 1'b0;
      bus.cfg_k_len  = 10'd0;
      bus.cfg_a_base = 12'd0;
      bus.cfg_w_base = 12'd0;
      bus.abort      = 1'b0;
      bus.out_ready  = 1'b0;

      // Reset values
      #3;
      check_all_zero("rst");
      tick();
      tick();
      rstn = 1'b1;
      check("rel_ready_before_edge", 32'(bus.cfg_ready), 32'd0);
      tick();
      check("rel_ready", 32'(bus.cfg_ready), 32'd1);
      check("rel_busy",  32'(bus.busy),      32'd0);

      // Abort in IDLE is ignored
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("idle_abort_ready", 32'(bus.cfg_ready), 32'd1);
      check("idle_abort_busy",  32'(bus.busy),      32'd0);

      // Basic job: A=1..4, W=2 -> 20
      run_job("j4", 4, 12'h010, 12'h200, 32'd20, 0, 1'b0, 0, 12'h0, 12'h0, 1'b0);
      // Zero-length job
      run_job("k0", 0, 12'h050, 12'h060, 32'd0, 0, 1'b0, 0, 12'h0, 12'h0, 1'b0);
      // Result held 5 cycles with the next descriptor waiting, then back-to-back
      run_job("hold", 2, 12'h020, 12'h220, model_acc(2, 12'h020, 12'h220), 5, 1'b1,
              3, 12'h030, 12'h230, 1'b0);
      run_job("b2b", 3, 12'h030, 12'h230, model_acc(3, 12'h030, 12'h230), 0, 1'b0,
              0, 12'h0, 12'h0, 1'b0);
      // Address wrap
      run_job("wrap", 3, 12'hFFE, 12'h300, model_acc(3, 12'hFFE, 12'h300), 0, 1'b0,
              0, 12'h0, 12'h0, 1'b0);
      // Abort coincident with the result handshake
      run_job("abhs", 1, 12'h040, 12'h240, model_acc(1, 12'h040, 12'h240), 0, 1'b0,
              0, 12'h0, 12'h0, 1'b1);

      // Abort in the second FETCH cycle
      bus.cfg_valid  = 1'b1;
      bus.cfg_k_len  = 10'd5;
      bus.cfg_a_base = 12'h060;
      bus.cfg_w_base = 12'h260;
      tick();
      bus.cfg_valid = 1'b0;
      check("ab_clr", 32'(bus.pe_clear), 32'd1);
      tick();
      check("ab_f0_rd", 32'(bus.mem_rd_en), 32'd1);
      tick();
      check("ab_f1_a", 32'(bus.a_addr), 32'h061);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("ab_busy",  32'(bus.busy),      32'd0);
      check("ab_ready", 32'(bus.cfg_ready), 32'd1);
      check("ab_rd",    32'(bus.mem_rd_en), 32'd0);
      check("ab_en",    32'(bus.pe_enable), 32'd0);
      check("ab_ov",    32'(bus.out_valid), 32'd0);
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("ab_after_ov%0d", c), 32'(bus.out_valid), 32'd0);
         check($sformatf("ab_after_en%0d", c), 32'(bus.pe_enable), 32'd0);
      end
      run_job("post_ab", 2, 12'h070, 12'h270, model_acc(2, 12'h070, 12'h270), 0, 1'b0,
              0, 12'h0, 12'h0, 1'b0);

      // Reset pulsed during FETCH
      bus.cfg_valid  = 1'b1;
      bus.cfg_k_len  = 10'd6;
      bus.cfg_a_base = 12'h080;
      bus.cfg_w_base = 12'h280;
      tick();
      bus.cfg_valid = 1'b0;
      tick();
      tick();
      check("mrst_pre_rd", 32'(bus.mem_rd_en), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_all_zero("mrst");
      tick();
      tick();
      rstn = 1'b1;
      check("mrst_rel_ready", 32'(bus.cfg_ready), 32'd0);
      tick();
      check("mrst_ready", 32'(bus.cfg_ready), 32'd1);
      run_job("post_rst", 4, 12'h010, 12'h200, 32'd20, 0, 1'b0, 0, 12'h0, 12'h0, 1'b0);

      // Maximum reduction length
      run_job("kmax", 1023, 12'h100, 12'h800, model_acc(1023, 12'h100, 12'h800), 0, 1'b0,
              0, 12'h0, 12'h0, 1'b0);

      tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
